// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 decryption sequencer.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXPAND = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ROUND  = 3'd3,
        ST_DONE   = 3'd4
    } aes_dec_state_t;

    localparam int AES_NUM_ROUNDS = 10;

    typedef logic [127:0] aes_block_t;

    localparam logic [7:0] AES_RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (x & {8{b[i]}});
            x   = {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic aes_block_t inv_shift_rows(input aes_block_t s);
        aes_block_t o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic aes_block_t inv_sub_bytes(input aes_block_t s);
        aes_block_t o;
        o = 128'h0;
        for (int k = 0; k < 16; k++) begin
            o[127 - 8*k -: 8] = inv_sbox(s[127 - 8*k -: 8]);
        end
        return o;
    endfunction

    function automatic aes_block_t inv_mix_columns(input aes_block_t s);
        aes_block_t o;
        logic [7:0] a [4];
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r] = s[127 - 8*(r + 4*c) -: 8];
            end
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = gf_mul(8'h0e, a[r]) ^ gf_mul(8'h0b, a[(r + 1) % 4])
                                          ^ gf_mul(8'h0d, a[(r + 2) % 4]) ^ gf_mul(8'h09, a[(r + 3) % 4]);
            end
        end
        return o;
    endfunction

    function automatic aes_block_t key_expand(input aes_block_t prev, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        t  = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])} ^ {rc, 24'h000000};
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64] ^ w0;
        w2 = prev[63:32] ^ w1;
        w3 = prev[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_round_key_file.sv
// Eleven-entry round-key store: one write port, three combinational read ports.
module aes_round_key_file
    import aes_pkg::*;
(
    input  logic       clk_i,
    input  logic       we_i,
    input  logic [3:0] widx_i,
    input  aes_block_t wdata_i,
    output aes_block_t last_o,
    input  logic [3:0] ridx_i,
    output aes_block_t round_o,
    input  logic [3:0] pidx_i,
    output aes_block_t prev_o
);

    aes_block_t rk_q [0:10];

    // Key contents carry no reset; they are always rewritten before use.
    always_ff @(posedge clk_i) begin
        if (we_i && (widx_i <= 4'd10)) begin
            rk_q[widx_i] <= wdata_i;
        end
    end

    assign last_o  = rk_q[10];
    assign round_o = rk_q[ridx_i];
    assign prev_o  = rk_q[pidx_i];

endmodule

// File: rtl/aes_dec_sequencer.sv
// Iterative AES-128 decryption controller: key expansion, one inverse round per clock.
module aes_dec_sequencer
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key,
    output logic         key_loaded,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] cipher,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);

    aes_dec_state_t state_q;
    logic [3:0]     idx_q;
    logic [3:0]     r_q;
    aes_block_t     data_q;
    aes_block_t     plaintext_q;
    logic           key_loaded_q;
    logic           out_valid_q;

    logic           rk_we_s;
    logic [3:0]     rk_widx_s;
    aes_block_t     rk_wdata_s;
    aes_block_t     rk_last_s;
    aes_block_t     rk_round_s;
    aes_block_t     rk_prev_s;
    logic [7:0]     rcon_s;
    aes_block_t     round_add_s;
    aes_block_t     round_mix_s;

    aes_round_key_file u_rk_file (
        .clk_i   (clock),
        .we_i    (rk_we_s),
        .widx_i  (rk_widx_s),
        .wdata_i (rk_wdata_s),
        .last_o  (rk_last_s),
        .ridx_i  (r_q),
        .round_o (rk_round_s),
        .pidx_i  (idx_q - 4'd1),
        .prev_o  (rk_prev_s)
    );

    // Inverse-round datapath and expansion round constant.
    always_comb begin
        if ((idx_q >= 4'd1) && (idx_q <= 4'd10)) begin
            rcon_s = AES_RCON[idx_q];
        end else begin
            rcon_s = 8'h00;
        end
        round_add_s = inv_sub_bytes(inv_shift_rows(data_q)) ^ rk_round_s;
        round_mix_s = inv_mix_columns(round_add_s);
    end

    // Round-key write port: raw key on accept, expanded keys during EXPAND.
    always_comb begin
        rk_we_s    = 1'b0;
        rk_widx_s  = idx_q;
        rk_wdata_s = key_expand(rk_prev_s, rcon_s);
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (key_valid) begin
                    rk_we_s    = 1'b1;
                    rk_widx_s  = 4'd0;
                    rk_wdata_s = key;
                end else begin
                    rk_we_s    = 1'b0;
                end
            end
            ST_EXPAND: rk_we_s = 1'b1;
            default:   rk_we_s = 1'b0;
        endcase
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= 4'd0;
            r_q          <= 4'd0;
            data_q       <= 128'h0;
            plaintext_q  <= 128'h0;
            key_loaded_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_WAIT: begin
                    if (key_valid) begin
                        idx_q        <= 4'd1;
                        key_loaded_q <= 1'b0;
                        state_q      <= ST_EXPAND;
                    end else if (in_valid && (state_q == ST_WAIT)) begin
                        data_q  <= cipher ^ rk_last_s;
                        r_q     <= 4'(NUM_ROUNDS - 1);
                        state_q <= ST_ROUND;
                    end
                end
                ST_EXPAND: begin
                    if (idx_q == 4'(NUM_ROUNDS)) begin
                        key_loaded_q <= 1'b1;
                        idx_q        <= 4'd0;
                        state_q      <= ST_WAIT;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                ST_ROUND: begin
                    if (r_q == 4'd0) begin
                        plaintext_q <= round_add_s;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        data_q <= round_mix_s;
                        r_q    <= r_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign key_ready  = (state_q == ST_IDLE) || (state_q == ST_WAIT);
    assign in_ready   = (state_q == ST_WAIT) && !key_valid;
    assign busy       = (state_q == ST_EXPAND) || (state_q == ST_ROUND) || (state_q == ST_DONE);
    assign key_loaded = key_loaded_q;
    assign out_valid  = out_valid_q;
    assign plaintext  = plaintext_q;

endmodule

// File: doc/aes_dec_sequencer.md
# aes_dec_sequencer

Iterative AES-128 decryption controller. It owns the round-key schedule and a single inverse-round datapath (the `invSubBytes`, `invShiftRows` and `InvMixColumns` stages plus AddRoundKey), and it sequences one round per clock. Upstream logic loads a key and streams ciphertext blocks through valid/ready handshakes. Each block's plaintext is returned on a valid/ready output port.

## Interface
Parameters:
- `NUM_ROUNDS`, default 10: number of AES rounds; only 10 (AES-128) is supported.

Ports:
- `clock`  in  1  single clock for the block; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  a new 128-bit key is offered on `key`.
- `key_ready`  out  1  the block can accept a key this cycle.
- `key`  in  128  cipher key, FIPS-197 byte order (byte 0 at [127:120]).
- `key_loaded`  out  1  all 11 round keys are valid.
- `in_valid`  in  1  a ciphertext block is offered on `cipher`.
- `in_ready`  out  1  the block can accept a ciphertext block this cycle.
- `cipher`  in  128  ciphertext block.
- `out_valid`  out  1  `plaintext` holds a finished result.
- `out_ready`  in  1  the consumer accepts the result.
- `plaintext`  out  128  decrypted block; registered output.
- `busy`  out  1  high in EXPAND, ROUND and DONE.

## Operation
- FSM states: IDLE (no key), EXPAND, WAIT (key loaded, no block in flight), ROUND, DONE.
- A handshake completes on a rising edge where valid && ready.
- Key accept:
  - `key_ready` = state ∈ {IDLE, WAIT}.
  - On accept: rk[0] ← `key`, idx ← 1, `key_loaded` ← 0, go to EXPAND.
- EXPAND:
  - Each cycle rk[idx] ← KeyExpansion(rk[idx-1], rcon[idx]), then idx++.
  - After rk[10] is written: `key_loaded` ← 1, go to WAIT.
- Block accept:
  - `in_ready` = (state == WAIT) && !`key_valid`. A key offered in WAIT takes priority over a ciphertext block.
  - On accept: data ← `cipher` ^ rk[10], r ← 9, go to ROUND.
- ROUND (r = 9 down to 1): data ← InvMixColumns(InvSubBytes(InvShiftRows(data)) ^ rk[r]), then r--.
- ROUND (r = 0): `plaintext` ← InvSubBytes(InvShiftRows(data)) ^ rk[0], `out_valid` ← 1, go to DONE.
- DONE:
  - `plaintext` and `out_valid` hold stable until `out_ready`.
  - On the handshake: `out_valid` ← 0, go to WAIT.
  - No new key or block is accepted in DONE.
- Reset (asynchronous, any state, including mid-EXPAND or mid-ROUND):
  - state = IDLE, `key_loaded` = 0, `out_valid` = 0, `plaintext` = 0, counters = 0.
  - Round-key contents are don't-care.
- Reset values of the remaining outputs: `key_ready` = 1, `in_ready` = 0, `busy` = 0.
- Key reload from WAIT discards the old schedule. `in_ready` stays low until the new expansion completes.

## Timing
- Key latency: `key_loaded` rises 10 rising edges after the key-accept edge. `in_ready` is first high in the following cycle.
- Decrypt latency: `out_valid` rises 10 rising edges after the cipher-accept edge, i.e. 11 edges including the accept edge.
- Throughput: one block per 12 cycles when `out_ready` is held high (accept, 10 rounds, 1 DONE cycle).
- Next accept: earliest the cycle after the output handshake.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid` or `out_ready` to any output. The only exception is `in_ready`'s dependence on `key_valid`.
- Back-pressure: `out_ready` low for N cycles extends DONE by N cycles with no loss of data.

## Structure
- Package `aes_pkg` holds:
  - the state enum `aes_dec_state_t`;
  - `AES_NUM_ROUNDS` = 10;
  - the `aes_block_t` typedef (logic [127:0]);
  - the rcon[1:10] constant table;
  - shared `invSbox` and forward-sbox functions.
- Sub-module `aes_round_key_file`:
  - 11 × 128-bit register array;
  - one write port (idx, data, we) and three combinational read ports: rk[10] for the accept stage, rk[r] for the round, rk[idx-1] for expansion.
- The datapath reuses the existing `invSubBytes`, `invShiftRows` and `InvMixColumns` instances plus one forward `keyExpand` instance driven with rcon[idx].

## Test plan
- Reset, then key 000102030405060708090a0b0c0d0e0f:
  - `key_loaded` rises exactly 10 edges after accept;
  - the internal rk[10] equals 13111d7fe3944a17f307a78b4d2b30c5.
- Same key, cipher 69c4e0d86a7b0430d8cdb78070b4c55a:
  - `plaintext` = 00112233445566778899aabbccddeeff;
  - `out_valid` rises at accept + 10 edges.
- Key 2b7e151628aed2a6abf7158809cf4f3c, cipher 3925841d02dc09fbdc118597196a0b32:
  - `plaintext` = 3243f6a8885a308d313198a2e0370734;
  - hold `out_ready` = 0 for 5 cycles; `plaintext` stays stable and `busy` = 1 throughout.
- Back-to-back blocks with `out_ready` = 1: two FIPS vectors are accepted 12 cycles apart and both results are correct.
- In WAIT, `key_valid` and `in_valid` asserted together:
  - the key is accepted and `in_ready` = 0;
  - after re-expansion the block decrypts under the new key.
- Assert `reset_n` low mid-ROUND (r = 5):
  - all outputs return to reset values immediately;
  - `key_loaded` = 0 and `in_ready` = 0 until a new key is loaded.
